// File: rtl/triangle_list_sequencer.sv
// Per-frame triangle list engine: reads a coloured triangle list from the SPI
// register file (or a built-in test pattern) and issues one rasterizer go per triangle.
module triangle_list_sequencer #(
  parameter int HORIZ_RESOLUTION = 80,
  parameter int VERT_RESOLUTION  = 60,
  parameter int COLOR_DEPTH      = 12,
  parameter int REG_ADDR_WIDTH   = 6,
  parameter int LIST_BASE        = 1,
  parameter int MAX_TRIANGLES    = 16,
  localparam int XW = $clog2(HORIZ_RESOLUTION),
  localparam int YW = $clog2(VERT_RESOLUTION),
  localparam int IW = $clog2(MAX_TRIANGLES)
) (
  input  logic                      i_clk,
  input  logic                      i_srst,
  input  logic                      i_new_frame,
  input  logic                      i_test_pattern_en,
  input  logic [1:0]                i_test_sel,
  output logic [REG_ADDR_WIDTH-1:0] o_reg_addr,
  input  logic [31:0]               i_reg_read_data,
  input  logic                      i_raster_done,
  output logic                      o_go,
  output logic [XW-1:0]             o_p0_x,
  output logic [XW-1:0]             o_p1_x,
  output logic [XW-1:0]             o_p2_x,
  output logic [YW-1:0]             o_p0_y,
  output logic [YW-1:0]             o_p1_y,
  output logic [YW-1:0]             o_p2_y,
  output logic [COLOR_DEPTH-1:0]    o_color,
  output logic [IW-1:0]             o_tri_index,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic                      o_overrun
);

  localparam int NW = $clog2(MAX_TRIANGLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_CNT, S_CAP_CNT, S_CAP_A, S_CAP_B, S_GO, S_GUARD, S_WAIT_DONE, S_TP_LOAD
  } state_t;

  typedef struct packed {
    logic [7:0] x0, y0, x1, y1, x2, y2;
  } raw_tri_t;

  state_t        state;
  logic [NW-1:0] tri_count;
  logic [IW-1:0] index;
  logic          test_mode;
  logic [1:0]    test_sel_q;
  logic [31:0]   word_a;
  raw_tri_t      tp_raw, rd_raw, cur_raw;

  function automatic logic [XW-1:0] clamp_x(input logic [7:0] v);
    if (int'(v) >= HORIZ_RESOLUTION) return XW'(HORIZ_RESOLUTION - 1);
    return v[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic [7:0] v);
    if (int'(v) >= VERT_RESOLUTION) return YW'(VERT_RESOLUTION - 1);
    return v[YW-1:0];
  endfunction

  function automatic logic [NW-1:0] clamp_count(input logic [7:0] v);
    if (int'(v) > MAX_TRIANGLES) return NW'(MAX_TRIANGLES);
    return NW'(v);
  endfunction

  function automatic logic [REG_ADDR_WIDTH-1:0] addr_a(input int k);
    return REG_ADDR_WIDTH'(LIST_BASE + 2 * k);
  endfunction

  function automatic logic [REG_ADDR_WIDTH-1:0] addr_b(input int k);
    return REG_ADDR_WIDTH'(LIST_BASE + 2 * k + 1);
  endfunction

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    tp_raw = '0;
    unique case (test_sel_q)
      2'd0: tp_raw = '{8'd10, 8'd10, 8'd10, 8'd50, 8'd50, 8'd25};
      2'd1: tp_raw = '{8'(HORIZ_RESOLUTION / 2), 8'd5, 8'd5, 8'(VERT_RESOLUTION - 5),
                       8'(HORIZ_RESOLUTION - 5), 8'(VERT_RESOLUTION - 5)};
      2'd2: tp_raw = '{8'd3, 8'd3, 8'd37, 8'd37, 8'd7, 8'd7};
      2'd3: tp_raw = '{8'd10, 8'd10, 8'd50, 8'd10, 8'd25, 8'd50};
      default: tp_raw = '0;
    endcase
  end

  // Word A was captured a cycle earlier; word B is on the read bus during CAP_B.
  assign rd_raw  = '{word_a[7:0], word_a[15:8], word_a[23:16], word_a[31:24],
                     i_reg_read_data[7:0], i_reg_read_data[15:8]};
  assign cur_raw = (state == S_TP_LOAD) ? tp_raw : rd_raw;

  // o_reg_addr is loaded one state ahead so that read data lines up with the capture state.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      // NOTE: reset is sampled on the clock edge only; every state and output register is cleared.
      state        <= S_IDLE;
      tri_count    <= '0;
      index        <= '0;
      test_mode    <= 1'b0;
      test_sel_q   <= '0;
      word_a       <= '0;
      o_reg_addr   <= '0;
      o_go         <= 1'b0;
      o_p0_x       <= '0;
      o_p1_x       <= '0;
      o_p2_x       <= '0;
      o_p0_y       <= '0;
      o_p1_y       <= '0;
      o_p2_y       <= '0;
      o_color      <= '0;
      o_tri_index  <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register updates from pre-edge values.
      o_go         <= 1'b0;
      o_frame_done <= 1'b0;
      o_overrun    <= i_new_frame && (state != S_IDLE);
      unique case (state)
        S_IDLE: if (i_new_frame) begin
          test_mode  <= i_test_pattern_en;
          test_sel_q <= i_test_sel;
          index      <= '0;
          o_busy     <= 1'b1;
          o_reg_addr <= '0;
          state      <= i_test_pattern_en ? S_TP_LOAD : S_RD_CNT;
        end
        S_RD_CNT: begin
          o_reg_addr <= addr_a(0);
          state      <= S_CAP_CNT;
        end
        S_CAP_CNT: begin
          tri_count <= clamp_count(i_reg_read_data[7:0]);
          index     <= '0;
          if (i_reg_read_data[7:0] == 8'd0) begin
            o_frame_done <= 1'b1;
            o_busy       <= 1'b0;
            o_reg_addr   <= '0;
            state        <= S_IDLE;
          end else begin
            o_reg_addr <= addr_b(0);
            state      <= S_CAP_A;
          end
        end
        S_CAP_A: begin
          word_a <= i_reg_read_data;
          state  <= S_CAP_B;
        end
        S_CAP_B, S_TP_LOAD: begin
          o_p0_x      <= clamp_x(cur_raw.x0);
          o_p0_y      <= clamp_y(cur_raw.y0);
          o_p1_x      <= clamp_x(cur_raw.x1);
          o_p1_y      <= clamp_y(cur_raw.y1);
          o_p2_x      <= clamp_x(cur_raw.x2);
          o_p2_y      <= clamp_y(cur_raw.y2);
          o_tri_index <= index;
          o_color     <= (state == S_TP_LOAD) ? '1 : i_reg_read_data[16 +: COLOR_DEPTH];
          if (state == S_TP_LOAD) tri_count <= NW'(1);
          o_go        <= 1'b1;
          state       <= S_GO;
        end
        S_GO: begin
          // Test mode never touches the register file.
          if (!test_mode) o_reg_addr <= addr_a(int'(index) + 1);
          state <= S_GUARD;
        end
        S_GUARD: state <= S_WAIT_DONE;
        S_WAIT_DONE: if (i_raster_done) begin
          if (int'(index) == int'(tri_count) - 1) begin
            o_frame_done <= 1'b1;
            o_busy       <= 1'b0;
            o_reg_addr   <= '0;
            state        <= S_IDLE;
          end else begin
            index      <= index + 1'b1;
            o_reg_addr <= addr_b(int'(index) + 1);
            state      <= S_CAP_A;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
